// File: rtl/pll_lock_supervisor.sv
// Video PLL bring-up supervisor: pulses PLL reset, waits for lock with timeout/retry,
// qualifies a stable-lock window, then releases the core reset. Handles lock loss and PAL/NTSC switching.
module pll_lock_supervisor #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned CNT_W               = 17
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mode_pal_req,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       pll_sel,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_count
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lock_meta, lock_s;
    logic             mode_meta, mode_s;
    logic             mode_chg_c;
    logic [1:0]       retry_inc_c;
    logic             retry_exhausted_c;

    // Two-flop synchronisers for the asynchronous lock and mode inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            mode_meta <= 1'b0;
            mode_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
            mode_meta <= mode_pal_req;
            mode_s    <= mode_meta;
        end
    end

    assign mode_chg_c        = (mode_s != pll_sel);
    assign retry_inc_c       = (retry_count == 2'd3) ? 2'd3 : retry_count + 2'd1;
    assign retry_exhausted_c = (32'(retry_count) >= MAX_RETRIES);

    // Sequencer; a mode change outranks lock loss and timeout outside RST
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_RST;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            pll_sel     <= 1'b0;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
            fail        <= 1'b0;
            retry_count <= 2'd0;
        end else if (state != ST_RST && mode_chg_c) begin
            state       <= ST_RST;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
            fail        <= 1'b0;
            retry_count <= 2'd0;
        end else begin
            case (state)
                ST_RST: begin
                    pll_sel <= mode_s;
                    if (cnt == RST_LAST) begin
                        state   <= ST_WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        if (retry_exhausted_c) begin
                            state <= ST_FAIL;
                            fail  <= 1'b1;
                        end else begin
                            state       <= ST_RST;
                            retry_count <= retry_inc_c;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state       <= ST_RUN;
                        cnt         <= '0;
                        sys_reset_n <= 1'b1;
                        ready       <= 1'b1;
                        retry_count <= 2'd0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state       <= ST_RST;
                        cnt         <= '0;
                        pll_rst     <= 1'b1;
                        sys_reset_n <= 1'b0;
                        ready       <= 1'b0;
                        retry_count <= retry_inc_c;
                    end
                end
                ST_FAIL: begin
                    pll_rst     <= 1'b1;
                    sys_reset_n <= 1'b0;
                    fail        <= 1'b1;
                end
                default: begin
                    state   <= ST_RST;
                    cnt     <= '0;
                    pll_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with shortened cycle parameters.
// Outputs are packed as {pll_rst, pll_sel, sys_reset_n, ready, fail, retry_count[1:0]}.
module tb_pll_lock_supervisor;

    logic       clk;
    logic       reset_n;
    logic       mode_pal_req;
    logic       pll_locked;
    logic       pll_rst;
    logic       pll_sel;
    logic       sys_reset_n;
    logic       ready;
    logic       fail;
    logic [1:0] retry_count;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic sel_glitch = 1'b0;
    logic prev_sel   = 1'b0;

    typedef struct {
        int unsigned ticks;
        logic        locked;
        logic        mode;
        logic [6:0]  exp;
    } vec_t;

    vec_t vecs [12];

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES   (16),
        .LOCK_STABLE_CYCLES (64),
        .LOCK_TIMEOUT_CYCLES(128),
        .MAX_RETRIES        (3),
        .CNT_W              (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mode_pal_req(mode_pal_req),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .pll_sel     (pll_sel),
        .sys_reset_n (sys_reset_n),
        .ready       (ready),
        .fail        (fail),
        .retry_count (retry_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // pll_sel must never move while the core is out of reset
    always @(negedge clk) begin
        if (sys_reset_n && (pll_sel != prev_sel))
            sel_glitch <= 1'b1;
        prev_sel <= pll_sel;
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [6:0] exp);
        logic [6:0] act;
        act = {pll_rst, pll_sel, sys_reset_n, ready, fail, retry_count};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (pll_rst,pll_sel,sys_reset_n,ready,fail,retry)",
                     nm, act, exp);
        end
    endtask

    initial begin
        // Power-up in PAL with lock arriving 100 cycles after pll_rst falls, then a RUN lock loss
        vecs[0]  = '{ticks: 15, locked: 1'b0, mode: 1'b1, exp: 7'b1100000};
        vecs[1]  = '{ticks: 1,  locked: 1'b0, mode: 1'b1, exp: 7'b0100000};
        vecs[2]  = '{ticks: 99, locked: 1'b0, mode: 1'b1, exp: 7'b0100000};
        vecs[3]  = '{ticks: 66, locked: 1'b1, mode: 1'b1, exp: 7'b0100000};
        vecs[4]  = '{ticks: 1,  locked: 1'b1, mode: 1'b1, exp: 7'b0111000};
        vecs[5]  = '{ticks: 10, locked: 1'b1, mode: 1'b1, exp: 7'b0111000};
        vecs[6]  = '{ticks: 2,  locked: 1'b0, mode: 1'b1, exp: 7'b0111000};
        vecs[7]  = '{ticks: 1,  locked: 1'b0, mode: 1'b1, exp: 7'b1100001};
        vecs[8]  = '{ticks: 15, locked: 1'b1, mode: 1'b1, exp: 7'b1100001};
        vecs[9]  = '{ticks: 1,  locked: 1'b1, mode: 1'b1, exp: 7'b0100001};
        vecs[10] = '{ticks: 64, locked: 1'b1, mode: 1'b1, exp: 7'b0100001};
        vecs[11] = '{ticks: 1,  locked: 1'b1, mode: 1'b1, exp: 7'b0111000};

        reset_n      = 1'b0;
        pll_locked   = 1'b0;
        mode_pal_req = 1'b1;
        tick(3);
        chk("reset_values", 7'b1000000);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            pll_locked   = vecs[i].locked;
            mode_pal_req = vecs[i].mode;
            tick(vecs[i].ticks);
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Mode change PAL->NTSC in RUN: core reset drops while pll_sel is still PAL
        mode_pal_req = 1'b0;
        tick(2);  chk("mode_pre_sync", 7'b0111000);
        tick(1);  chk("mode_drop_sys", 7'b1100000);
        tick(1);  chk("mode_sel_upd",  7'b1000000);
        tick(79); chk("mode_relock_pre", 7'b0000000);
        tick(1);  chk("mode_relock_run", 7'b0011000);

        // One-cycle lock glitch mid-STABLE restarts the stable window, no retry charged
        mode_pal_req = 1'b1;
        tick(3);  chk("ntsc_to_pal", 7'b1000000);
        tick(45);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(2);  chk("glitch_wait", 7'b0100000);
        tick(64); chk("glitch_pre_run", 7'b0100000);
        tick(1);  chk("glitch_run", 7'b0111000);

        // Simultaneous lock loss and mode change: mode path wins, retry stays 0
        pll_locked   = 1'b0;
        mode_pal_req = 1'b0;
        tick(3);  chk("both_drop", 7'b1100000);
        tick(1);  chk("both_sel", 7'b1000000);
        pll_locked = 1'b1;
        tick(40); chk("mid_stable", 7'b0000000);
        #1 reset_n = 1'b0;
        #1 chk("async_reset", 7'b1000000);

        // Lock never arrives: three retries, then FAIL until a mode change
        pll_locked   = 1'b0;
        mode_pal_req = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(144); chk("timeout1", 7'b1100001);
        tick(144); chk("timeout2", 7'b1100010);
        tick(144); chk("timeout3", 7'b1100011);
        tick(143); chk("last_wait", 7'b0100011);
        tick(1);   chk("fail_entry", 7'b1100111);
        tick(50);  chk("fail_hold", 7'b1100111);
        mode_pal_req = 1'b0;
        tick(2);   chk("fail_pre_sync", 7'b1100111);
        tick(1);   chk("fail_exit", 7'b1100000);
        tick(1);   chk("fail_exit_sel", 7'b1000000);
        tick(14);  chk("new_pulse_hi", 7'b1000000);
        tick(1);   chk("new_pulse_lo", 7'b0000000);

        n_vec++;
        if (sel_glitch !== 1'b0) begin
            n_bad++;
            $display("FAIL sel_stable: pll_sel moved while sys_reset_n=1 (flag %b, expected 0)", sel_glitch);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
